// File: rtl/solve_sequencer.sv
// Run controller for the grid solver: turns a start key edge into a clear/launch
// sequence, supervises each attempt with a watchdog and retries with the next seed.
module solve_sequencer #(
    parameter int SEED_W    = 8,
    parameter int MAX_TRIES = 4,
    parameter int TIMEOUT   = 1048576,
    parameter int CYC_W     = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start_req,
    input  logic [SEED_W-1:0]                seed_in,
    output logic                             grid_reset,
    output logic                             grid_start,
    output logic [SEED_W-1:0]                grid_seed,
    input  logic                             grid_done,
    input  logic                             grid_success,
    output logic                             busy,
    output logic                             done,
    output logic                             success,
    output logic                             timed_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]   attempts,
    output logic [CYC_W-1:0]                 cycles
);

    localparam int AT_W = $clog2(MAX_TRIES + 1);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [AT_W-1:0] LAST_TRY = AT_W'(MAX_TRIES);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_WAIT,
        S_RETRY,
        S_REPORT
    } state_t;

    state_t          state_reg;
    logic            clear_cnt_reg;
    logic [WD_W-1:0] watchdog_reg;
    logic            start_q;
    logic            start_edge;

    // start_q resets high so a key held down through reset cannot launch a run
    assign start_edge = start_req & ~start_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            clear_cnt_reg <= 1'b0;
            watchdog_reg  <= '0;
            start_q       <= 1'b1;
            grid_reset    <= 1'b1;
            grid_start    <= 1'b0;
            grid_seed     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            success       <= 1'b0;
            timed_out     <= 1'b0;
            attempts      <= '0;
            cycles        <= '0;
        end else begin
            start_q    <= start_req;
            grid_start <= 1'b0;

            // busy mirrors the current state, so this counts cycles spent busy
            if (busy && (cycles != {CYC_W{1'b1}})) begin
                cycles <= cycles + CYC_W'(1);
            end

            case (state_reg)
                S_IDLE, S_REPORT: begin
                    grid_reset <= 1'b0;
                    if (start_edge) begin
                        grid_seed     <= seed_in;
                        attempts      <= AT_W'(1);
                        cycles        <= '0;
                        done          <= 1'b0;
                        success       <= 1'b0;
                        timed_out     <= 1'b0;
                        busy          <= 1'b1;
                        grid_reset    <= 1'b1;
                        clear_cnt_reg <= 1'b0;
                        state_reg     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (clear_cnt_reg) begin
                        grid_reset <= 1'b0;
                        grid_start <= 1'b1;
                        state_reg  <= S_LAUNCH;
                    end else begin
                        clear_cnt_reg <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    watchdog_reg <= '0;
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    watchdog_reg <= watchdog_reg + WD_W'(1);
                    // a finished solver beats a watchdog expiry on the same cycle
                    if (grid_done) begin
                        timed_out <= 1'b0;
                        if (grid_success) begin
                            success   <= 1'b1;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= S_REPORT;
                        end else begin
                            state_reg <= S_RETRY;
                        end
                    end else if (watchdog_reg == WD_LAST) begin
                        timed_out <= 1'b1;
                        state_reg <= S_RETRY;
                    end
                end
                S_RETRY: begin
                    if (attempts == LAST_TRY) begin
                        success   <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= S_REPORT;
                    end else begin
                        grid_seed     <= grid_seed + SEED_W'(1);
                        attempts      <= attempts + AT_W'(1);
                        grid_reset    <= 1'b1;
                        clear_cnt_reg <= 1'b0;
                        state_reg     <= S_CLEAR;
                    end
                end
                default: begin
                    grid_reset <= 1'b1;
                    busy       <= 1'b0;
                    state_reg  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_solve_sequencer.sv
// Bench for solve_sequencer: a behavioural grid responder plus an arithmetic
// run-time/result model, with directed corner runs and randomized runs.
module tb_solve_sequencer;

    localparam int SEED_W    = 8;
    localparam int MAX_TRIES = 4;
    localparam int TIMEOUT   = 16;
    localparam int CYC_W     = 6;
    localparam int AT_W      = $clog2(MAX_TRIES + 1);
    localparam int CYC_MAX   = (1 << CYC_W) - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start_req = 1'b0;
    logic [SEED_W-1:0] seed_in = '0;
    logic              grid_reset;
    logic              grid_start;
    logic [SEED_W-1:0] grid_seed;
    logic              grid_done = 1'b0;
    logic              grid_success = 1'b0;
    logic              busy;
    logic              done;
    logic              success;
    logic              timed_out;
    logic [AT_W-1:0]   attempts;
    logic [CYC_W-1:0]  cycles;

    always #5 clock = ~clock;

    solve_sequencer #(
        .SEED_W   (SEED_W),
        .MAX_TRIES(MAX_TRIES),
        .TIMEOUT  (TIMEOUT),
        .CYC_W    (CYC_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_req   (start_req),
        .seed_in     (seed_in),
        .grid_reset  (grid_reset),
        .grid_start  (grid_start),
        .grid_seed   (grid_seed),
        .grid_done   (grid_done),
        .grid_success(grid_success),
        .busy        (busy),
        .done        (done),
        .success     (success),
        .timed_out   (timed_out),
        .attempts    (attempts),
        .cycles      (cycles)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Grid responder: attempt k raises done lat_tab[k] cycles after its launch pulse
    // (0 = never finishes); results are cleared whenever grid_reset is high.
    int                lat_tab[MAX_TRIES];
    bit                ok_tab[MAX_TRIES];
    logic [SEED_W-1:0] seen_seed[MAX_TRIES];
    int                starts_seen = 0;
    int                resp_cnt = 0;
    bit                resp_ok = 1'b0;

    always @(negedge clock) begin
        if (grid_reset === 1'b1) begin
            grid_done    = 1'b0;
            grid_success = 1'b0;
            resp_cnt     = 0;
        end else if (grid_start === 1'b1) begin
            if (starts_seen < MAX_TRIES) begin
                seen_seed[starts_seen] = grid_seed;
                resp_cnt = lat_tab[starts_seen];
                resp_ok  = ok_tab[starts_seen];
            end
            starts_seen++;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                grid_done    = 1'b1;
                grid_success = resp_ok;
            end
        end
    end

    task automatic set_all(input int lat, input bit ok);
        for (int k = 0; k < MAX_TRIES; k++) begin
            lat_tab[k] = lat;
            ok_tab[k]  = ok;
        end
    endtask

    // One full run from IDLE/REPORT; called and returns on a falling edge.
    task automatic run(input logic [SEED_W-1:0] seed, input bit glitch);
        int                exp_total;
        int                exp_tries;
        int                waitlen;
        int                exp_cyc;
        int                n;
        bit                timed;
        bit                exp_ok;
        bit                exp_to;
        logic [SEED_W-1:0] exp_seed;

        // Expected outcome: each attempt costs clear(2)+launch(1)+wait, plus one
        // retry-decision cycle unless it succeeded.
        exp_total = 0;
        exp_tries = 0;
        exp_ok    = 1'b0;
        exp_to    = 1'b0;
        for (int k = 0; k < MAX_TRIES; k++) begin
            exp_tries = k + 1;
            timed     = (lat_tab[k] == 0) || (lat_tab[k] > TIMEOUT);
            waitlen   = timed ? TIMEOUT : lat_tab[k];
            exp_total += 3 + waitlen;
            exp_to    = timed;
            exp_ok    = !timed && ok_tab[k];
            if (exp_ok) break;
            exp_total += 1;
        end
        exp_cyc = (exp_total > CYC_MAX) ? CYC_MAX : exp_total;

        starts_seen = 0;
        seed_in     = seed;
        start_req   = 1'b1;
        @(negedge clock);
        n = 1;
        start_req = 1'b0;
        check("clr_busy", busy, 1);
        check("clr_done", done, 0);
        check("clr_cycles", cycles, 0);
        check("clr_grid_reset", grid_reset, 1);
        check("clr_attempts", attempts, 1);
        check("clr_seed", grid_seed, seed);

        while (done !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
            if (glitch && n == 4) start_req = 1'b1;
            if (n == 5) start_req = 1'b0;
        end

        check("done_cycle", n, 1 + exp_total);
        check("success", success, exp_ok);
        check("timed_out", timed_out, exp_to);
        check("attempts", attempts, exp_tries);
        check("cycles", cycles, exp_cyc);
        check("busy_idle", busy, 0);
        check("start_pulses", starts_seen, exp_tries);
        for (int k = 0; k < exp_tries; k++) begin
            exp_seed = seed + SEED_W'(k);
            check("attempt_seed", seen_seed[k], exp_seed);
        end
        $display("run seed=%02h glitch=%0b tries=%0d success=%0b timed_out=%0b cycles=%0d done_at=t+%0d",
                 seed, glitch, attempts, success, timed_out, cycles, n);
    endtask

    initial begin
        int n;

        // Reset with start held high: nothing may launch after release.
        set_all(0, 1'b0);
        start_req = 1'b1;
        reset     = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_grid_reset", grid_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_attempts", attempts, 0);
        check("rst_cycles", cycles, 0);
        check("rst_grid_start", grid_start, 0);
        reset = 1'b1;
        @(negedge clock);
        check("rel_grid_reset", grid_reset, 0);
        check("rel_busy", busy, 0);
        repeat (5) @(negedge clock);
        check("held_start_pulses", starts_seen, 0);
        check("held_start_busy", busy, 0);
        start_req = 1'b0;
        @(negedge clock);

        // Nominal: success 10 cycles after launch.
        set_all(10, 1'b1);
        run(8'h3C, 1'b0);
        // Exhaustion with seed wrap, from REPORT.
        set_all(3, 1'b0);
        run(8'hFE, 1'b0);
        // Pure watchdog, cycles saturate; a start pulse mid-WAIT is ignored.
        set_all(0, 1'b0);
        run(8'h10, 1'b1);
        // Done coincides with watchdog expiry: done wins, not a timeout.
        set_all(TIMEOUT, 1'b0);
        run(8'h20, 1'b0);
        set_all(TIMEOUT, 1'b1);
        run(8'h21, 1'b0);
        // One past the boundary is a timeout, then success.
        set_all(TIMEOUT + 1, 1'b0);
        lat_tab[1] = 2;
        ok_tab[1]  = 1'b1;
        run(8'h22, 1'b1);

        // Reset during WAIT of the second attempt.
        set_all(5, 1'b0);
        starts_seen = 0;
        seed_in     = 8'h55;
        start_req   = 1'b1;
        @(negedge clock);
        start_req = 1'b0;
        n = 0;
        while (starts_seen < 2 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("second_attempt_seen", (starts_seen >= 2) ? 1 : 0, 1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_grid_reset", grid_reset, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_attempts", attempts, 0);
        check("mid_rst_cycles", cycles, 0);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rel_grid_reset", grid_reset, 0);
        repeat (10) @(negedge clock);
        check("mid_rel_no_launch", starts_seen, 2);
        check("mid_rel_busy", busy, 0);
        $display("run reset-mid-wait attempts=%0d busy=%0b", attempts, busy);

        // Randomized runs.
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < MAX_TRIES; k++) begin
                lat_tab[k] = $urandom_range(0, TIMEOUT + 4);
                ok_tab[k]  = ($urandom_range(0, 1) == 1);
            end
            run(SEED_W'($urandom_range(0, 255)), ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/solve_sequencer.md
# solve_sequencer

Run controller that sits between the board keys/switches and the `grid` solver. It turns a start key press into a clean reset-and-launch sequence for `grid` and watches each attempt with a watchdog. On failure or timeout it retries with an incremented seed, up to a fixed attempt budget. It latches the final result, the attempt count and the elapsed cycles for the HEX/LED display logic.

## Interface

Parameters:
- `SEED_W` — 8 — width of the solver seed.
- `MAX_TRIES` — 4 — attempt budget, ≥1.
- `TIMEOUT` — 1048576 — cycles allowed in WAIT per attempt, ≥2.
- `CYC_W` — 32 — width of the elapsed-cycle counter.

Ports:
- `clock` in 1 — single clock, all logic on rising edge.
- `reset` in 1 — synchronous, active-low; clears all state when sampled low.
- `start_req` in 1 — level start request; only rising edges act.
- `seed_in` in `SEED_W` — initial seed, sampled on an accepted start edge.
- `grid_reset` out 1 — active-high reset to `grid`.
- `grid_start` out 1 — one-cycle launch pulse to `grid`.
- `grid_seed` out `SEED_W` — seed for the current attempt.
- `grid_done` in 1 — `grid` finished; level, held until `grid` is reset.
- `grid_success` in 1 — valid when `grid_done`=1.
- `busy` out 1 — attempt sequence in progress.
- `done` out 1 — result latched.
- `success` out 1 — final result; valid while `done`=1.
- `timed_out` out 1 — the last attempt ended by watchdog.
- `attempts` out `$clog2(MAX_TRIES+1)` — attempts started in this run.
- `cycles` out `CYC_W` — cycles spent busy in this run, saturating.

## Operation

- Edge detect:
  - `start_q` registers `start_req` and resets to 1, so a request held through reset does not fire.
  - An edge is `start_req & ~start_q`.
  - Edges are accepted only in IDLE or REPORT and ignored in every other state.
- States:
  - **IDLE**: outputs quiet. Start edge → CLEAR. On entry from the edge: `grid_seed`←`seed_in`, `attempts`←1, `cycles`←0, `done`←0, `success`←0, `timed_out`←0.
  - **CLEAR**: `grid_reset`=1 for exactly 2 cycles, then → LAUNCH.
  - **LAUNCH**: `grid_start`=1 for exactly 1 cycle, watchdog←0, then → WAIT.
  - **WAIT**: watchdog increments each cycle.
    - `grid_done & grid_success` → REPORT with `success`←1.
    - `grid_done & ~grid_success`, or watchdog == `TIMEOUT-1` with `grid_done`=0 → RETRY. Set `timed_out`←1 only in the watchdog case and clear it otherwise.
    - If `grid_done` and watchdog expiry coincide, `grid_done` wins and `timed_out`=0.
  - **RETRY**, 1 cycle:
    - If `attempts` == `MAX_TRIES` → REPORT with `success`←0.
    - Otherwise `grid_seed`←`grid_seed`+1, wrapping mod 2^`SEED_W` (0xFF→0x00); `attempts`+=1; → CLEAR.
  - **REPORT**: `done`=1. Results hold until a start edge, which does the same re-initialisation as from IDLE and → CLEAR.
- `busy`=1 in CLEAR, LAUNCH, WAIT and RETRY.
- `cycles` increments every busy cycle and holds at all-ones once saturated.
- Reset values:
  - `grid_reset`=1 while `reset` is low, and 0 in the first cycle after release.
  - All other outputs 0; state IDLE.
  - Reset mid-run abandons the attempt and holds `grid` in reset.

## Timing

- Start edge sampled at cycle t:
  - CLEAR occupies t+1 and t+2 (`grid_reset`=1).
  - LAUNCH is t+3 (`grid_start`=1).
  - WAIT starts at t+4.
- `grid_done` sampled in WAIT at cycle w → `done`=1 at w+1 on success, or RETRY at w+1.
- A retry's CLEAR begins at w+2. Retry overhead between attempts is 4 cycles (RETRY, CLEAR×2, LAUNCH).
- Watchdog: WAIT lasts at most `TIMEOUT` cycles per attempt.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Nominal: `seed_in`=0x3C, start edge, model `grid` asserts done+success 10 cycles after `grid_start` → one `grid_start` pulse; `grid_seed`=0x3C; `done`=1 and `success`=1 at t+14; `attempts`=1; `cycles`=13; `timed_out`=0.
- Retry to exhaustion: `MAX_TRIES`=4, `seed_in`=0xFE, `grid` always fails → seeds 0xFE, 0xFF, 0x00, 0x01 observed; 4 `grid_start` pulses; `done`=1, `success`=0, `attempts`=4.
- Watchdog: `TIMEOUT`=16, `grid` never done → each attempt ends after exactly 16 WAIT cycles; `timed_out`=1 at REPORT. Also drive `grid_done`=1 on the expiry cycle → RETRY with `timed_out`=0.
- Start filtering: hold `start_req` high through reset release → nothing starts. Pulse start during WAIT → ignored. Start edge in REPORT → clean rerun with `done` cleared and `cycles` reset to 0.
- Reset mid-run: drive `reset` low during WAIT of attempt 2 → next cycle state IDLE, `grid_reset`=1, `busy`/`done`/`attempts`/`cycles`=0. After release, `grid_reset`=0 and the block waits for a fresh edge.
